// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction fetch and a data
// access requester. Data wins arbitration unless it has starved the
// instruction side for MAXD consecutive completions. Each granted access is
// bounded by a TIMEOUT-cycle watchdog and can also be aborted by RAM ERROR.
//
//   state | meaning
//   IDLE  | no owner, RAM strobes low, arbitrate pending requests
//   IBUS  | instruction fetch owns the RAM port
//   DBUS  | data read/write owns the RAM port
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int MAXD    = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  output logic        err
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int SW = (MAXD < 2) ? 1 : $clog2(MAXD + 1);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q;
  logic [SW-1:0]   dstreak_q;

  logic dreq, owner_req, acc, done, abort, starved;

  assign dreq      = dREN | dWEN;
  assign acc       = (ramstate == RS_ACCESS);
  assign owner_req = ((state_q == IBUS) && iREN) || ((state_q == DBUS) && dreq);
  assign done      = owner_req && acc;
  // ACCESS in the timeout cycle still counts as a completion
  assign abort     = owner_req && !acc &&
                     ((ramstate == RS_ERROR) || (tcnt_q == TW'(TIMEOUT)));
  assign starved   = iREN && (dstreak_q == SW'(MAXD));

  // next-state: arbitrate in IDLE, leave a bus state on completion, abort or withdrawal
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dreq && !starved) state_d = DBUS;
        else if (iREN)        state_d = IBUS;
      end
      IBUS, DBUS: begin
        if (!owner_req || done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM-side and requester-side outputs decoded from state and live inputs
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    err      = abort;
    case (state_q)
      IBUS: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iload   = ramload;
        iwait   = !done;
      end
      DBUS: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = !dWEN;
        dload    = ramload;
        dwait    = !done;
      end
      default: ;
    endcase
  end

  // state register; reset drops any in-flight access at once
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // watchdog: held at zero in IDLE so every grant starts from zero
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                tcnt_q <= '0;
    else if (state_q == IDLE) tcnt_q <= '0;
    else if (!acc)            tcnt_q <= tcnt_q + TW'(1);
  end

  // consecutive data completions while an instruction fetch is waiting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                              dstreak_q <= '0;
    else if (!iREN)                         dstreak_q <= '0;
    else if (done && state_q == IBUS)       dstreak_q <= '0;
    else if (done && state_q == DBUS && dstreak_q != SW'(MAXD))
                                            dstreak_q <= dstreak_q + SW'(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles a granted access may wait for ACCESS before abort.
REQ-002 Parameter: MAXD, default 4, max consecutive data grants while an instruction request is pending.
REQ-003 Ports: CLK  in  1  clock; all state updates on rising edge.
REQ-004 Ports: nRST  in  1  reset, asynchronous, active-low.
REQ-005 Ports: iREN  in  1  instruction read request from datapath; held until iwait low.
REQ-006 Ports: iaddr  in  32  instruction address.
REQ-007 Ports: dREN, dWEN  in  1 each  data read and write requests; held until dwait low.
REQ-008 Ports: daddr, dstore  in  32 each  data address and write data.
REQ-009 Ports: ramload  in  32  RAM read data.
REQ-010 Ports: ramstate  in  2  RAM status, FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-011 Ports: iwait, dwait  out  1 each  low for exactly the cycle the access completes.
REQ-012 Ports: iload, dload  out  32 each  read data returned to requester.
REQ-013 Ports: ramaddr, ramstore  out  32 each  address and write data to RAM.
REQ-014 Ports: ramREN, ramWEN  out  1 each  RAM strobes; never both high.
REQ-015 Ports: err  out  1  one-cycle pulse on access abort.

Function
REQ-016 FSM states: IDLE, IBUS, DBUS; state is registered, all outputs combinational from state plus inputs.
REQ-017 IDLE grant: data request (dREN|dWEN) wins unless iREN=1 and dstreak==MAXD, then instruction wins; otherwise iREN -> IBUS; none -> stay IDLE.
REQ-018 Grant latency: request sampled in IDLE at edge N; RAM strobes driven from cycle N+1; no RAM strobe in IDLE.
REQ-019 IBUS: ramaddr=iaddr, ramREN=1, ramWEN=0; iload=ramload.
REQ-020 DBUS: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0; else ramREN=1; dload=ramload; dWEN wins if dREN and dWEN both high.
REQ-021 Completion: in IBUS/DBUS with ramstate==ACCESS, the owning wait goes low that cycle, next state IDLE.
REQ-022 Both waits are high in every other cycle, including IDLE.
REQ-023 Back-to-back: after completion at least one IDLE cycle occurs before next grant.
REQ-024 Request withdrawal: if the owner's request drops while in IBUS/DBUS, next state IDLE, no completion, no err.
REQ-025 Timeout counter: 8+ bit tcnt cleared on entry to IBUS/DBUS; increments each non-ACCESS cycle there.
REQ-026 Timeout: when tcnt==TIMEOUT, or ramstate==ERROR, err=1 for that cycle, wait stays high, next state IDLE.
REQ-027 Aborted requests are re-arbitrated from IDLE like new requests.
REQ-028 Starvation counter dstreak: +1 on each data completion while iREN=1, saturating at MAXD.
REQ-029 dstreak clears on instruction completion or any cycle with iREN=0.
REQ-030 iload/dload/ramaddr/ramstore are 0 when not in the matching state.

Reset
REQ-031 nRST low asynchronously forces state IDLE, tcnt=0, dstreak=0.
REQ-032 During and after reset until a grant: iwait=1, dwait=1, ramREN=0, ramWEN=0, err=0, ramaddr=0, ramstore=0, iload=0, dload=0.
REQ-033 Reset asserted mid-access aborts immediately; strobes drop in the same cycle, no err pulse.

Verification
REQ-034 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 from cycle 2, iwait low one cycle, iload=0xDEADBEEF.
REQ-035 iREN and dWEN both high, daddr=0x80, dstore=0x1234 -> DBUS first, ramWEN=1, ramstore=0x1234; dwait low on ACCESS; then IBUS.
REQ-036 iREN held, dREN asserted continuously, MAXD=4 -> exactly 4 data completions, then one instruction grant, dstreak=0 after.
REQ-037 dREN=1, ramstate held BUSY, TIMEOUT=255 -> err pulse after 255 wait cycles, dwait never low, state IDLE, then re-grant.
REQ-038 ramstate=ERROR during IBUS -> err pulse same cycle, iwait high, IDLE next cycle.
REQ-039 nRST low during DBUS with ramWEN=1 -> ramWEN=0 immediately, all outputs at reset values, first grant after release follows REQ-017.
